// File: rtl/disp_digit_sel.sv
// Registered display-source selector: live digits, set-mode digits with
// a blinking edit position, pause freeze and a timed lap snapshot.
module disp_digit_sel #(
  parameter int NDIG       = 4,
  parameter int DW         = 4,
  parameter int BLINK_HALF = 25_000_000,
  parameter int LAP_HOLD   = 100_000_000,
  parameter logic [DW-1:0] BLANK = DW'(4'hF),
  localparam int EW = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NDIG*DW-1:0] run_digits,
  input  logic [NDIG*DW-1:0] init_digits,
  input  logic               set,
  input  logic               pause,
  input  logic               lap,
  input  logic [EW-1:0]      edit_pos,
  output logic [NDIG*DW-1:0] out_digits,
  output logic [1:0]         state,
  output logic               blink_on
);

  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int LW = $clog2(LAP_HOLD + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_HALF - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LAP_HOLD - 1);

  typedef enum logic [1:0] {
    S_LIVE   = 2'b00,
    S_SET    = 2'b01,
    S_FROZEN = 2'b10,
    S_LAP    = 2'b11
  } state_t;

  state_t               st_q, st_d;
  logic [NDIG*DW-1:0]   out_d;
  logic [NDIG*DW-1:0]   blank_word;
  logic [BW-1:0]        blink_cnt, blink_cnt_d;
  logic                 blink_d;
  logic [LW-1:0]        lap_cnt, lap_cnt_d;

  assign state = st_q;

  // init_digits with the edited position replaced by the dark code
  always_comb begin
    blank_word = init_digits;
    for (int i = 0; i < NDIG; i++) begin
      if (edit_pos == EW'(i))
        blank_word[i*DW +: DW] = BLANK;
    end
  end

  always_comb begin
    st_d        = st_q;
    out_d       = out_digits;
    blink_cnt_d = blink_cnt;
    blink_d     = blink_on;
    lap_cnt_d   = lap_cnt;

    if (set) begin
      st_d      = S_SET;
      lap_cnt_d = '0;
      if (st_q != S_SET) begin
        blink_cnt_d = '0;
        blink_d     = 1'b1;
      end else if (blink_cnt == B_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_on;
      end else begin
        blink_cnt_d = blink_cnt + BW'(1);
      end
      out_d = blink_d ? init_digits : blank_word;
    end else begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
      case (st_q)
        S_SET: begin
          if (pause) begin
            st_d = S_FROZEN;
          end else begin
            st_d  = S_LIVE;
            out_d = run_digits;
          end
        end
        S_FROZEN: begin
          if (!pause) begin
            st_d  = S_LIVE;
            out_d = run_digits;
          end
        end
        S_LAP: begin
          if (pause) begin
            st_d      = S_FROZEN;
            lap_cnt_d = '0;
          end else if (lap) begin
            out_d     = run_digits;
            lap_cnt_d = '0;
          end else if (lap_cnt == L_LAST) begin
            st_d      = S_LIVE;
            out_d     = run_digits;
            lap_cnt_d = '0;
          end else begin
            lap_cnt_d = lap_cnt + LW'(1);
          end
        end
        default: begin
          if (pause) begin
            st_d = S_FROZEN;
          end else if (lap) begin
            st_d      = S_LAP;
            out_d     = run_digits;
            lap_cnt_d = '0;
          end else begin
            out_d = run_digits;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= S_LIVE;
      out_digits <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      lap_cnt    <= '0;
    end else begin
      st_q       <= st_d;
      out_digits <= out_d;
      blink_cnt  <= blink_cnt_d;
      blink_on   <= blink_d;
      lap_cnt    <= lap_cnt_d;
    end
  end

endmodule

// File: tb/tb_disp_digit_sel.sv
// Scoreboard bench for disp_digit_sel: directed scenarios then random
// traffic, checked against a cycle-age based reference model.
module tb_disp_digit_sel;

  localparam int NDIG = 4;
  localparam int DW   = 4;
  localparam int BH   = 4;
  localparam int LH   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] run_digits  = '0;
  logic [15:0] init_digits = '0;
  logic        set   = 1'b0;
  logic        pause = 1'b0;
  logic        lap   = 1'b0;
  logic [1:0]  edit_pos = '0;
  logic [15:0] out_digits;
  logic [1:0]  state;
  logic        blink_on;

  disp_digit_sel #(
    .NDIG(NDIG), .DW(DW), .BLINK_HALF(BH), .LAP_HOLD(LH), .BLANK(4'hF)
  ) dut (
    .clk(clk), .rst(rst),
    .run_digits(run_digits), .init_digits(init_digits),
    .set(set), .pause(pause), .lap(lap), .edit_pos(edit_pos),
    .out_digits(out_digits), .state(state), .blink_on(blink_on)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  s;
    logic        b;
  } exp_t;

  exp_t q[$];
  int compared   = 0;
  int mismatched = 0;

  // reference model: mode 0 live, 1 set, 2 frozen, 3 lap
  int          m_mode;
  int          m_set_age;
  int          m_lap_age;
  logic [15:0] m_disp;
  logic        m_blink;

  function automatic void model_reset();
    m_mode = 0; m_set_age = 0; m_lap_age = 0;
    m_disp = '0; m_blink = 1'b1;
  endfunction

  function automatic void model_step();
    m_blink = 1'b1;
    if (set) begin
      m_set_age = (m_mode == 1) ? m_set_age + 1 : 0;
      m_mode    = 1;
      m_blink   = ((m_set_age / BH) % 2) == 0;
      m_disp    = init_digits;
      if (!m_blink) m_disp[int'(edit_pos)*DW +: DW] = 4'hF;
    end else if (m_mode == 1) begin
      if (pause) m_mode = 2;
      else begin m_mode = 0; m_disp = run_digits; end
    end else if (pause) begin
      m_mode = 2;
    end else if (m_mode == 2) begin
      m_mode = 0; m_disp = run_digits;
    end else if (lap) begin
      m_mode = 3; m_lap_age = 0; m_disp = run_digits;
    end else if (m_mode == 3) begin
      m_lap_age++;
      if (m_lap_age >= LH) begin m_mode = 0; m_disp = run_digits; end
    end else begin
      m_disp = run_digits;
    end
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got out=%h state=%b blink=%b, want out=%h state=%b blink=%b",
               name, got.d, got.s, got.b, exp.d, exp.s, exp.b);
    end
  endtask

  function automatic exp_t dut_now();
    exp_t e;
    e.d = out_digits; e.s = state; e.b = blink_on;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] d, input logic [1:0] s, input logic b);
    exp_t e;
    e.d = d; e.s = s; e.b = b;
    return e;
  endfunction

  // drive one cycle of inputs at the current (negedge) time, then wait
  task automatic cycle(input logic s, input logic p, input logic l,
                       input logic [15:0] r, input logic [15:0] i,
                       input logic [1:0] e);
    exp_t x;
    set = s; pause = p; lap = l;
    run_digits = r; init_digits = i; edit_pos = e;
    model_step();
    x.d = m_disp; x.s = 2'(m_mode); x.b = m_blink;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    q.delete();
    #1;
    check(name, dut_now(), mk(16'h0000, 2'b00, 1'b1));
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      check("scoreboard", dut_now(), e);
    end
  end

  initial begin : stim
    logic s, p;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset("reset");

    cycle(0, 0, 0, 16'h1234, 16'h0000, 2'd0);
    check("live_1234", dut_now(), mk(16'h1234, 2'b00, 1'b1));

    repeat (4) cycle(1, 0, 0, 16'h5555, 16'h0930, 2'd1);
    check("set_visible", dut_now(), mk(16'h0930, 2'b01, 1'b1));
    cycle(1, 0, 0, 16'h5555, 16'h0930, 2'd1);
    check("set_blank", dut_now(), mk(16'h09F0, 2'b01, 1'b0));
    repeat (3) cycle(1, 0, 0, 16'h5555, 16'h0930, 2'd1);
    cycle(1, 0, 0, 16'h5555, 16'h0930, 2'd1);
    check("set_visible2", dut_now(), mk(16'h0930, 2'b01, 1'b1));
    cycle(0, 0, 0, 16'h4321, 16'h0930, 2'd1);
    check("set_exit_live", dut_now(), mk(16'h4321, 2'b00, 1'b1));

    cycle(0, 0, 1, 16'h0101, 16'h0000, 2'd0);
    check("lap_snap", dut_now(), mk(16'h0101, 2'b11, 1'b1));
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 16'($urandom()), 16'h0, 2'd0);
    check("lap_hold_end", dut_now(), mk(16'h0101, 2'b11, 1'b1));
    cycle(0, 0, 0, 16'h7777, 16'h0, 2'd0);
    check("lap_expire", dut_now(), mk(16'h7777, 2'b00, 1'b1));

    cycle(0, 0, 1, 16'h1111, 16'h0, 2'd0);
    repeat (3) cycle(0, 0, 0, 16'h2222, 16'h0, 2'd0);
    cycle(0, 0, 1, 16'h0202, 16'h0, 2'd0);
    check("lap_restart", dut_now(), mk(16'h0202, 2'b11, 1'b1));
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 16'($urandom()), 16'h0, 2'd0);
    check("lap_restart_hold", dut_now(), mk(16'h0202, 2'b11, 1'b1));

    cycle(0, 1, 0, 16'h3333, 16'h0, 2'd0);
    check("lap_to_frozen", dut_now(), mk(16'h0202, 2'b10, 1'b1));
    repeat (8) cycle(0, 1, 1, 16'h4444, 16'h0, 2'd0);
    check("frozen_hold", dut_now(), mk(16'h0202, 2'b10, 1'b1));
    cycle(0, 0, 1, 16'h5656, 16'h0, 2'd0);
    check("frozen_exit", dut_now(), mk(16'h5656, 2'b00, 1'b1));

    cycle(1, 1, 1, 16'h6666, 16'h8888, 2'd2);
    check("set_priority", dut_now(), mk(16'h8888, 2'b01, 1'b1));
    repeat (5) cycle(1, 0, 0, 16'h6666, 16'h8888, 2'd2);
    @(negedge clk);
    do_reset("reset_mid_set");

    s = 1'b0; p = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) s = ~s;
      if ($urandom_range(0, 7) == 0)  p = ~p;
      if ($urandom_range(0, 499) == 0) begin
        do_reset("reset_random");
      end
      cycle(s, p, $urandom_range(0, 5) == 0, 16'($urandom()),
            16'($urandom()), 2'($urandom_range(0, 3)));
    end

    @(negedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
